// File: rtl/apb_master_arbiter_if.sv
// Requester-side and APB-side signals of the two-requester APB master arbiter.
interface apb_master_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req0,   req1;
    logic [ADDR_W-1:0] addr0,  addr1;
    logic              write0, write1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              done0,  done1;
    logic              err0,   err1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;
    logic              Pwrite;
    logic [3:0]        Pselx;
    logic              Penable;
    logic [DATA_W-1:0] Prdata;

    modport master (
        input  req0, req1, addr0, addr1, write0, write1, wdata0, wdata1, Prdata,
        output done0, done1, err0, err1, rdata0, rdata1,
               Paddr, Pwdata, Pwrite, Pselx, Penable
    );

    modport slave (
        output req0, req1, addr0, addr1, write0, write1, wdata0, wdata1, Prdata,
        input  done0, done1, err0, err1, rdata0, rdata1,
               Paddr, Pwdata, Pwrite, Pselx, Penable
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master port between two requesters, with
// region/slave decode and the two-cycle SETUP/ACCESS sequence (no Pready).
module apb_master_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter logic [5:0]  REGION = 6'b100000
) (
    input  logic                 clock,
    input  logic                 Hresetn,
    apb_master_arbiter_if.master bus
);
    typedef enum logic [1:0] { IDLE, SETUP, ACCESS } state_t;

    state_t            state;
    logic              last;      // last-served requester; 1 after reset so req0 wins the first tie
    logic              cur;       // requester owning the transfer on the bus

    logic              elig0, elig1;
    logic              win;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_write;
    logic              win_valid;
    logic [1:0]        win_sel;
    logic              grant;

    // Eligibility, round-robin pick and region decode for the current cycle.
    always_comb begin
        elig0     = bus.req0 && !bus.done0 && !((state == ACCESS) && !cur);
        elig1     = bus.req1 && !bus.done1 && !((state == ACCESS) &&  cur);
        win       = (elig0 && elig1) ? ~last : elig1;
        win_addr  = win ? bus.addr1  : bus.addr0;
        win_wdata = win ? bus.wdata1 : bus.wdata0;
        win_write = win ? bus.write1 : bus.write0;
        win_valid = (win_addr[ADDR_W-1 -: 6] == REGION);
        win_sel   = win_addr[ADDR_W-7 -: 2];
        // An out-of-region winner is taken only from IDLE, so its error done
        // never lands in the same cycle as the done of an ending ACCESS.
        grant     = (elig0 || elig1) &&
                    ((state == IDLE) || ((state == ACCESS) && win_valid));
    end

    always_ff @(posedge clock) begin
        if (!Hresetn) begin
            state       <= IDLE;
            last        <= 1'b1;
            cur         <= 1'b0;
            bus.Paddr   <= '0;
            bus.Pwdata  <= '0;
            bus.Pwrite  <= 1'b0;
            bus.Pselx   <= '0;
            bus.Penable <= 1'b0;
            bus.done0   <= 1'b0;
            bus.done1   <= 1'b0;
            bus.err0    <= 1'b0;
            bus.err1    <= 1'b0;
            bus.rdata0  <= '0;
            bus.rdata1  <= '0;
        end else begin
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            bus.err0  <= 1'b0;
            bus.err1  <= 1'b0;

            case (state)
                IDLE: state <= IDLE;
                SETUP: begin
                    bus.Penable <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    bus.Penable <= 1'b0;
                    bus.Pselx   <= '0;
                    state       <= IDLE;
                    if (cur) begin
                        bus.done1 <= 1'b1;
                        if (!bus.Pwrite) bus.rdata1 <= bus.Prdata;
                    end else begin
                        bus.done0 <= 1'b1;
                        if (!bus.Pwrite) bus.rdata0 <= bus.Prdata;
                    end
                end
                default: state <= IDLE;
            endcase

            // A new grant overrides the bus-idle values set above.
            if (grant) begin
                last <= win;
                if (win_valid) begin
                    cur         <= win;
                    state       <= SETUP;
                    bus.Paddr   <= win_addr;
                    bus.Pwdata  <= win_wdata;
                    bus.Pwrite  <= win_write;
                    bus.Pselx   <= 4'(4'b0001 << win_sel);
                    bus.Penable <= 1'b0;
                end else if (win) begin
                    bus.done1  <= 1'b1;
                    bus.err1   <= 1'b1;
                    bus.rdata1 <= '0;
                end else begin
                    bus.done0  <= 1'b1;
                    bus.err0   <= 1'b1;
                    bus.rdata0 <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared each cycle against a timeline model.
module tb_apb_master_arbiter;
    localparam int NC = 4096;

    logic clock = 1'b0;
    logic hresetn;

    apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .REGION(6'b100000)) dut (
        .clock   (clock),
        .Hresetn (hresetn),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;
    int edge_n = 0;

    // Expected outputs per edge index: pulses/strobes scheduled ahead, held values as updates.
    bit [3:0]  s_psel   [NC];
    bit        s_pen    [NC];
    bit [1:0]  s_done   [NC];
    bit [1:0]  s_err    [NC];
    bit        s_upd_bus[NC];
    bit [31:0] s_paddr  [NC];
    bit [31:0] s_pwdata [NC];
    bit        s_pwrite [NC];
    bit [1:0]  s_upd_rd [NC];
    bit [31:0] s_rd0    [NC];
    bit [31:0] s_rd1    [NC];
    bit        was_rst  [NC];

    bit m_last;
    bit m_inflight;
    bit m_gwho;
    bit m_gwrite;
    int m_gedge;
    int m_free;
    int m_blk[2];
    int done_edge[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s edge=%0d got=%h want=%h", name, edge_n, act, exp);
        end
    endtask

    // Transaction-level model: a grant at edge e occupies the bus for edges e..e+1
    // and completes at e+2; a decode error completes at e itself.
    task automatic model_step();
        bit          el0, el1, w, valid, acc;
        logic [31:0] a;
        int          e;
        edge_n++;
        e = edge_n;
        was_rst[e] = !hresetn;
        if (!hresetn) begin
            for (int k = e; k < e + 4; k++) begin
                s_psel[k] = '0; s_pen[k] = 1'b0; s_done[k] = '0; s_err[k] = '0;
            end
            s_upd_bus[e] = 1'b1; s_paddr[e] = '0; s_pwdata[e] = '0; s_pwrite[e] = 1'b0;
            s_upd_rd[e] = 2'b11; s_rd0[e] = '0; s_rd1[e] = '0;
            m_last = 1'b1; m_inflight = 1'b0; m_free = e + 1;
            m_blk[0] = 0; m_blk[1] = 0; done_edge[0] = -10; done_edge[1] = -10;
            return;
        end
        acc = m_inflight && (e == m_gedge + 2);
        if (acc) begin
            m_inflight = 1'b0;
            if (!m_gwrite) begin
                s_upd_rd[e][m_gwho] = 1'b1;
                if (m_gwho) s_rd1[e] = bus.Prdata;
                else        s_rd0[e] = bus.Prdata;
            end
        end
        if (e >= m_free) begin
            el0 = bus.req0 && (e > m_blk[0]);
            el1 = bus.req1 && (e > m_blk[1]);
            if (el0 || el1) begin
                w     = (el0 && el1) ? !m_last : el1;
                a     = w ? bus.addr1 : bus.addr0;
                valid = (a[31:26] == 6'b100000);
                if (valid) begin
                    m_last = w; m_inflight = 1'b1; m_gedge = e; m_gwho = w;
                    m_gwrite = w ? bus.write1 : bus.write0;
                    s_psel[e] = 4'b0001 << a[25:24];
                    s_psel[e+1] = s_psel[e];
                    s_pen[e+1] = 1'b1;
                    s_done[e+2][w] = 1'b1;
                    s_upd_bus[e] = 1'b1; s_paddr[e] = a;
                    s_pwdata[e] = w ? bus.wdata1 : bus.wdata0;
                    s_pwrite[e] = m_gwrite;
                    m_free = e + 2; m_blk[w] = e + 3; done_edge[w] = e + 2;
                end else if (!acc) begin
                    m_last = w;
                    s_done[e][w] = 1'b1; s_err[e][w] = 1'b1;
                    s_upd_rd[e][w] = 1'b1;
                    if (w) s_rd1[e] = '0; else s_rd0[e] = '0;
                    m_free = e + 1; m_blk[w] = e + 1; done_edge[w] = e;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    // Per-cycle comparison against the model plus bus protocol invariants.
    initial begin : compare
        logic [31:0] x_paddr, x_pwdata, x_rd0, x_rd1, prev_paddr;
        logic        x_pwrite, prev_pen, need_pen;
        int          e;
        x_paddr = '0; x_pwdata = '0; x_rd0 = '0; x_rd1 = '0; x_pwrite = 1'b0;
        prev_paddr = '0; prev_pen = 1'b0; need_pen = 1'b0;
        forever begin
            @(negedge clock);
            if (edge_n > 0) begin
                e = edge_n;
                if (s_upd_bus[e]) begin
                    x_paddr = s_paddr[e]; x_pwdata = s_pwdata[e]; x_pwrite = s_pwrite[e];
                end
                if (s_upd_rd[e][0]) x_rd0 = s_rd0[e];
                if (s_upd_rd[e][1]) x_rd1 = s_rd1[e];
                chk("Pselx",   32'(bus.Pselx),   32'(s_psel[e]));
                chk("Penable", 32'(bus.Penable), 32'(s_pen[e]));
                chk("Paddr",   bus.Paddr,        x_paddr);
                chk("Pwdata",  bus.Pwdata,       x_pwdata);
                chk("Pwrite",  32'(bus.Pwrite),  32'(x_pwrite));
                chk("done0",   32'(bus.done0),   32'(s_done[e][0]));
                chk("done1",   32'(bus.done1),   32'(s_done[e][1]));
                chk("err0",    32'(bus.err0),    32'(s_err[e][0]));
                chk("err1",    32'(bus.err1),    32'(s_err[e][1]));
                chk("rdata0",  bus.rdata0,       x_rd0);
                chk("rdata1",  bus.rdata1,       x_rd1);
                chk("psel_onehot0", 32'($onehot0(bus.Pselx)), 32'd1);
                chk("penable_twice", 32'(prev_pen & bus.Penable), 32'd0);
                chk("dual_done", 32'(bus.done0 & bus.done1), 32'd0);
                if (need_pen && !was_rst[e]) chk("paddr_then_penable", 32'(bus.Penable), 32'd1);
                need_pen   = (bus.Paddr !== prev_paddr) && !was_rst[e];
                prev_paddr = bus.Paddr;
                prev_pen   = bus.Penable;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a[31:26] = 6'b100000;
        return a;
    endfunction

    // One requester's random behaviour for the coming cycle.
    task automatic rnd_req(input int d_edge, inout logic r, inout logic [31:0] a,
                           inout logic w, inout logic [31:0] wd);
        if (r && (edge_n == d_edge + 1)) begin
            r = 1'($urandom_range(0, 1));
            if (r) begin a = rand_addr(); w = 1'($urandom_range(0, 1)); wd = $urandom; end
        end else if (!r) begin
            if ($urandom_range(0, 2) == 0) begin
                r = 1'b1; a = rand_addr(); w = 1'($urandom_range(0, 1)); wd = $urandom;
            end
        end else if ($urandom_range(0, 5) == 0) begin
            a = rand_addr(); w = 1'($urandom_range(0, 1)); wd = $urandom;
        end
    endtask

    initial begin : main
        logic        r;
        logic        w;
        logic [31:0] a, wd;
        hresetn = 1'b0;
        bus.req0 = 1'b0; bus.addr0 = '0; bus.write0 = 1'b0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.addr1 = '0; bus.write1 = 1'b0; bus.wdata1 = '0;
        bus.Prdata = 32'hDEAD_BEEF;
        step(); step();
        chk("rst_pselx", 32'(bus.Pselx), 32'd0);
        chk("rst_penable", 32'(bus.Penable), 32'd0);
        chk("rst_paddr", bus.Paddr, 32'd0);
        chk("rst_done0", 32'(bus.done0), 32'd0);
        hresetn = 1'b1;

        // Write from requester 0.
        bus.req0 = 1'b1; bus.addr0 = 32'h8000_0010; bus.write0 = 1'b1; bus.wdata0 = 32'hA5A5_0001;
        step();
        chk("wr_setup_pselx", 32'(bus.Pselx), 32'h1);
        chk("wr_setup_paddr", bus.Paddr, 32'h8000_0010);
        chk("wr_setup_pwdata", bus.Pwdata, 32'hA5A5_0001);
        chk("wr_setup_pwrite", 32'(bus.Pwrite), 32'd1);
        chk("wr_setup_penable", 32'(bus.Penable), 32'd0);
        step();
        chk("wr_access_penable", 32'(bus.Penable), 32'd1);
        step();
        chk("wr_done0", 32'(bus.done0), 32'd1);
        chk("wr_err0", 32'(bus.err0), 32'd0);
        step(); bus.req0 = 1'b0;

        // Read from requester 1, slave 3.
        bus.req1 = 1'b1; bus.addr1 = 32'h8300_0004; bus.write1 = 1'b0;
        step();
        chk("rd_pselx", 32'(bus.Pselx), 32'h8);
        step(); step();
        chk("rd_done1", 32'(bus.done1), 32'd1);
        chk("rd_rdata1", bus.rdata1, 32'hDEAD_BEEF);
        step(); bus.req1 = 1'b0;

        // Contention right after reset.
        hresetn = 1'b0; step(); hresetn = 1'b1;
        bus.req0 = 1'b1; bus.addr0 = 32'h8100_0000; bus.write0 = 1'b0;
        bus.req1 = 1'b1; bus.addr1 = 32'h8200_0000; bus.write1 = 1'b0;
        step();
        chk("tie_first_pselx", 32'(bus.Pselx), 32'h2);
        step();
        chk("tie_first_penable", 32'(bus.Penable), 32'd1);
        step();
        chk("tie_done0", 32'(bus.done0), 32'd1);
        chk("tie_second_pselx", 32'(bus.Pselx), 32'h4);
        chk("tie_second_setup_penable", 32'(bus.Penable), 32'd0);
        step(); bus.req0 = 1'b0;
        chk("tie_second_penable", 32'(bus.Penable), 32'd1);
        step();
        chk("tie_done1", 32'(bus.done1), 32'd1);
        chk("tie_done0_low", 32'(bus.done0), 32'd0);
        step();
        // Second tie: requester 1 was served last, so requester 0 goes first.
        bus.req0 = 1'b1; bus.addr0 = 32'h8000_0000;
        bus.req1 = 1'b1; bus.addr1 = 32'h8100_0000;
        step();
        chk("tie2_first_pselx", 32'(bus.Pselx), 32'h1);
        step(); step();
        chk("tie2_done0", 32'(bus.done0), 32'd1);
        chk("tie2_second_pselx", 32'(bus.Pselx), 32'h2);
        step(); bus.req0 = 1'b0;
        step();
        chk("tie2_done1", 32'(bus.done1), 32'd1);
        step(); bus.req1 = 1'b0;

        // Decode error.
        bus.req0 = 1'b1; bus.addr0 = 32'h9000_0000; bus.write0 = 1'b0;
        step();
        chk("err_done0", 32'(bus.done0), 32'd1);
        chk("err_err0", 32'(bus.err0), 32'd1);
        chk("err_rdata0", bus.rdata0, 32'd0);
        chk("err_pselx", 32'(bus.Pselx), 32'd0);
        step(); bus.req0 = 1'b0;
        chk("err_no_repeat", 32'(bus.done0), 32'd0);

        // Reset during ACCESS, then a clean retry.
        bus.req0 = 1'b1; bus.addr0 = 32'h8000_0100; bus.write0 = 1'b0;
        step(); step();
        chk("rsta_penable", 32'(bus.Penable), 32'd1);
        hresetn = 1'b0; bus.req0 = 1'b0;
        step();
        chk("rsta_pselx", 32'(bus.Pselx), 32'd0);
        chk("rsta_penable_low", 32'(bus.Penable), 32'd0);
        chk("rsta_paddr", bus.Paddr, 32'd0);
        chk("rsta_rdata1", bus.rdata1, 32'd0);
        hresetn = 1'b1;
        step();
        chk("rsta_no_done0", 32'(bus.done0), 32'd0);
        bus.req0 = 1'b1;
        step();
        chk("retry_pselx", 32'(bus.Pselx), 32'h1);
        step(); step();
        chk("retry_done0", 32'(bus.done0), 32'd1);
        chk("retry_rdata0", bus.rdata0, 32'hDEAD_BEEF);
        step(); bus.req0 = 1'b0;

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2500; i++) begin
            if (!hresetn) begin
                hresetn = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0;
            end else begin
                r = bus.req0; a = bus.addr0; w = bus.write0; wd = bus.wdata0;
                rnd_req(done_edge[0], r, a, w, wd);
                bus.req0 = r; bus.addr0 = a; bus.write0 = w; bus.wdata0 = wd;
                r = bus.req1; a = bus.addr1; w = bus.write1; wd = bus.wdata1;
                rnd_req(done_edge[1], r, a, w, wd);
                bus.req1 = r; bus.addr1 = a; bus.write1 = w; bus.wdata1 = wd;
                if ($urandom_range(0, 299) == 0) hresetn = 1'b0;
            end
            bus.Prdata = $urandom;
            step();
        end
        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
